uart_tx_buffered: RTL and testbench

//  Buffered UART transmitter, 8N1, LSB first. Accepts bytes from a local producer into an internal FIFO
//  and serialises them on tx back-to-back without idle gaps. Paired with the existing uart_rx as the

---
 rtl/uart_tx_buffered_pkg.sv | 19 +
 rtl/uart_tx_buffered_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_buffered.sv | 135 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: frame geometry and FSM state encoding.
// The state encoding matches the one used by the companion uart_rx.
package uart_tx_buffered_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Clocks per line bit; integer division truncates toward a slightly fast baud.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with show-ahead head: rd_data is the oldest entry whenever !empty,
// so the consumer captures it in the same cycle it asserts rd_en.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             wr_ok;
  logic             rd_ok;

  // A write while full is refused even if a read frees a slot in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   level_reg <= level_reg + LEVEL_ONE;
        2'b01:   level_reg <= level_reg - LEVEL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign level   = level_reg;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB first,
// back-to-back with no idle bit between frames.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int UART_BAUD_RATE = 9600,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rstn,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  output logic                         busy,
  output logic                         tx
);

  localparam int BAUD_CNT_MAX = baud_div(CLK_FREQ, UART_BAUD_RATE);
  localparam int BCW          = $clog2(BAUD_CNT_MAX);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT_MAX - 1);
  localparam logic [BCW-1:0] BAUD_ONE  = BCW'(1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t      state_reg, state_next;
  logic [BCW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_reg, tx_next;
  logic           overflow_reg;
  logic           pop;
  logic           baud_done;
  logic [7:0]     fifo_rd_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  assign baud_done = (baud_cnt_reg == BAUD_LAST);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          shift_next    = fifo_rd_data;
          baud_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == BIT_LAST) state_next   = ST_STOP;
          else                         bit_cnt_next = bit_cnt_reg + 3'd1;
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_ONE;
        end
      end
      default: begin
        // Chaining straight from STOP into START keeps frames contiguous.
        if (baud_done) begin
          baud_cnt_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_rd_data;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + BAUD_ONE;
        end
      end
    endcase

    // Line level is derived from the upcoming state so tx leaves a flop aligned with state_reg.
    case (state_next)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_next[bit_cnt_next];
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      overflow_reg <= wr_en && full;
    end
  end

  assign tx       = tx_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered at 10 clocks per bit with a 4-entry FIFO;
// an independent line monitor decodes tx and scores bytes against an expected queue.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int BITC     = 10;
  localparam int FRAME    = 10 * BITC;

  logic       sys_clk = 1'b0;
  logic       sys_rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, busy, tx;
  logic [2:0] fifo_level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mon_starts = 0;
  int ovf_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] burst_q[$];
  int start_cyc_q[$];

  uart_tx_buffered #(
    .UART_BAUD_RATE (BAUD),
    .CLK_FREQ       (CLK_FREQ),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Line monitor: finds a start bit, samples each bit at mid-cell, scores against exp_q.
  initial begin : monitor_blk
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge sys_clk);
      if (sys_rstn && tx === 1'b0) begin
        t0 = cyc;
        mon_starts++;
        repeat (BITC / 2 - 1) @(negedge sys_clk);
        tests++;
        if (tx !== 1'b0) begin
          fails++;
          $display("FAIL mon_start_bit: tx=%b required 0 (cyc %0d)", tx, cyc);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) @(negedge sys_clk);
          b[i] = tx;
        end
        repeat (BITC) @(negedge sys_clk);
        tests++;
        if (tx !== 1'b1) begin
          fails++;
          $display("FAIL mon_stop_bit: tx=%b required 1 (cyc %0d)", tx, cyc);
        end
        start_cyc_q.push_back(t0);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mon_unexpected: got %02h required none", b);
        end else begin
          if (b !== exp_q[0]) begin
            fails++;
            $display("FAIL mon_data: got %02h required %02h", b, exp_q[0]);
          end else begin
            $display("[TB] rx %02h start cyc %0d", b, t0);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drives burst_q on consecutive edges; counts overflow pulses that follow those edges.
  task automatic burst();
    ovf_cnt = 0;
    for (int i = 0; i < burst_q.size(); i++) begin
      @(negedge sys_clk);
      if (i > 0 && overflow === 1'b1) ovf_cnt++;
      wr_en   = 1'b1;
      wr_data = burst_q[i];
      $display("[TB] write %02h", burst_q[i]);
    end
    @(negedge sys_clk);
    if (overflow === 1'b1) ovf_cnt++;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_drain_timeout: busy=%b empty=%b required 0/1", name, busy, empty);
    end
    repeat (20) @(negedge sys_clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: %0d bytes not received, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    sys_rstn = 1'b0;
    repeat (3) @(negedge sys_clk);
    tests++;
    if ({tx, busy, empty, full, overflow} !== 5'b10100) begin
      fails++;
      $display("FAIL reset_flags: tx/busy/empty/full/ovf=%b required 10100",
               {tx, busy, empty, full, overflow});
    end
    tests++;
    if (fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL reset_level: got %0d required 0", fifo_level);
    end
    sys_rstn = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_single_byte();
    logic [9:0] f;
    int busy_cnt;
    f = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    @(negedge sys_clk);
    wr_en = 1'b1;
    wr_data = 8'hA5;
    @(negedge sys_clk);
    wr_en = 1'b0;
    tests++;
    if (tx !== 1'b1 || fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL single_after_write: tx=%b level=%0d required 1/1", tx, fifo_level);
    end
    @(negedge sys_clk);
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1) begin
      fails++;
      $display("FAIL single_latency: tx=%b busy=%b empty=%b required 0/1/1", tx, busy, empty);
    end
    busy_cnt = 1;
    for (int off = 1; off < 120; off++) begin
      @(negedge sys_clk);
      if (busy === 1'b1) busy_cnt++;
      if (off % BITC == BITC / 2 && off < FRAME) begin
        tests++;
        if (tx !== f[off / BITC]) begin
          fails++;
          $display("FAIL single_line_bit%0d: tx=%b required %b", off / BITC, tx, f[off / BITC]);
        end
      end
    end
    tests++;
    if (busy_cnt != FRAME) begin
      fails++;
      $display("FAIL single_busy_len: got %0d cycles required %0d", busy_cnt, FRAME);
    end
    wait_drain("single");
  endtask

  task automatic test_burst();
    burst_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (burst_q[i]) exp_q.push_back(burst_q[i]);
    start_cyc_q.delete();
    burst();
    // One byte is already in flight, so four back-to-back writes leave three queued.
    tests++;
    if (fifo_level !== 3'd3 || full !== 1'b0) begin
      fails++;
      $display("FAIL burst_level: level=%0d full=%b required 3/0", fifo_level, full);
    end
    wait_drain("burst");
    tests++;
    if (start_cyc_q.size() != 4) begin
      fails++;
      $display("FAIL burst_frames: got %0d required 4", start_cyc_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (start_cyc_q[i] - start_cyc_q[i-1] != FRAME) begin
          fails++;
          $display("FAIL burst_gap%0d: got %0d required %0d", i,
                   start_cyc_q[i] - start_cyc_q[i-1], FRAME);
        end
      end
    end
  endtask

  task automatic test_overflow();
    burst_q.delete();
    for (int i = 0; i < 6; i++) burst_q.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) exp_q.push_back(burst_q[i]);
    burst();
    tests++;
    if (ovf_cnt != 1 || fifo_level !== 3'd4 || full !== 1'b1) begin
      fails++;
      $display("FAIL overflow_pulse: ovf=%0d level=%0d full=%b required 1/4/1",
               ovf_cnt, fifo_level, full);
    end
    @(negedge sys_clk);
    tests++;
    if (overflow !== 1'b0 || fifo_level !== 3'd4) begin
      fails++;
      $display("FAIL overflow_one_cycle: ovf=%b level=%0d required 0/4", overflow, fifo_level);
    end
    wait_drain("overflow");
  endtask

  task automatic test_pop_collision(input int n);
    logic [7:0] extra;
    int lvl;
    burst_q.delete();
    for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
    lvl = (n >= 5) ? 4 : n - 1;
    for (int i = 0; i < ((n >= 5) ? 5 : n); i++) exp_q.push_back(burst_q[i]);
    burst();
    // Now just after edge k+n-1; the first frame's final STOP cycle ends at edge k+101.
    repeat (101 - n) @(negedge sys_clk);
    tests++;
    if (fifo_level !== 3'(lvl)) begin
      fails++;
      $display("FAIL collide%0d_pre_level: got %0d required %0d", n, fifo_level, lvl);
    end
    extra = 8'($urandom);
    wr_en = 1'b1;
    wr_data = extra;
    $display("[TB] write %02h at pop edge", extra);
    @(negedge sys_clk);
    wr_en = 1'b0;
    if (lvl == 4) begin
      tests++;
      if (overflow !== 1'b1 || fifo_level !== 3'd3) begin
        fails++;
        $display("FAIL collide_full: ovf=%b level=%0d required 1/3", overflow, fifo_level);
      end
    end else begin
      exp_q.push_back(extra);
      tests++;
      if (overflow !== 1'b0 || fifo_level !== 3'(lvl)) begin
        fails++;
        $display("FAIL collide_partial: ovf=%b level=%0d required 0/%0d", overflow, fifo_level, lvl);
      end
    end
    wait_drain("collide");
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    int starts_before;
    burst_q.delete();
    for (int i = 0; i < 3; i++) burst_q.push_back(8'($urandom));
    // The aborted frame's bits 0-3 were sent before reset; the line then reads idle high.
    exp_q.push_back(burst_q[0] | 8'hF0);
    burst();
    repeat (44) @(negedge sys_clk);
    sys_rstn = 1'b0;
    @(negedge sys_clk);
    tests++;
    if ({tx, busy, empty, overflow} !== 4'b1010 || fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL midreset_state: tx/busy/empty/ovf=%b level=%0d required 1010/0",
               {tx, busy, empty, overflow}, fifo_level);
    end
    sys_rstn = 1'b1;
    starts_before = mon_starts;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || mon_starts != starts_before) begin
      fails++;
      $display("FAIL midreset_quiet: bad=%0d new_frames=%0d required 0/0", bad,
               mon_starts - starts_before);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_partial: %0d frames undecoded, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random_bursts();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 7);
      burst_q.delete();
      for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
      // From idle: one byte goes straight to the shifter, four more fit in the FIFO.
      for (int i = 0; i < ((n > 5) ? 5 : n); i++) exp_q.push_back(burst_q[i]);
      burst();
      tests++;
      if (ovf_cnt != ((n > 5) ? n - 5 : 0)) begin
        fails++;
        $display("FAIL random_ovf n=%0d: got %0d required %0d", n, ovf_cnt, (n > 5) ? n - 5 : 0);
      end
      wait_drain("random");
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_pop_collision(5);
    test_pop_collision(3);
    test_reset_midframe();
    test_random_bursts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
